pipeline_control: RTL and testbench

// Stall/flush sequencer for the 5-stage pipeline. Handles four events:
// - load-use hazards
// - taken branches/jumps resolved in E
// - multi-cycle mul/div ops in E (start/done handshake with the mul/div unit)
// - data-memory wait states in M

---
 rtl/pipeline_control_pkg.sv | 14 +
 rtl/pipeline_control_sat_counter.sv | 19 +
 rtl/pipeline_control.sv | 117 +++++++++++
 tb/tb_pipeline_control.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_control_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipeline_control_pkg;

  localparam int unsigned REG_ADDR_BITS = 5;
  localparam int unsigned CTRL_STATE_BITS = 2;

  // Encoding 2'd3 is unused and is treated as CtrlRun.
  typedef enum logic [CTRL_STATE_BITS-1:0] {
    CtrlRun     = 2'd0,
    CtrlMdBusy  = 2'd1,
    CtrlMemWait = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/pipeline_control_sat_counter.sv
// Enable-driven saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_control.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken branch,
// multi-cycle mul/div and data-memory wait handling, plus a stall-cycle counter.
module pipeline_control
  import pipeline_control_pkg::*;
#(
  parameter int unsigned PERF_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [REG_ADDR_BITS-1:0] readRegister1D,
  input  logic [REG_ADDR_BITS-1:0] readRegister2D,
  input  logic [REG_ADDR_BITS-1:0] writeRegE,
  input  logic                     memReadE,
  input  logic                     pcSrcE,
  input  logic                     mulDivE,
  input  logic                     mulDivDone,
  input  logic                     memAccessM,
  input  logic                     dmemReady,
  output logic                     stallF,
  output logic                     stallD,
  output logic                     stallE,
  output logic                     stallM,
  output logic                     flushD,
  output logic                     flushE,
  output logic                     flushM,
  output logic                     flushW,
  output logic                     mulDivStart,
  output logic [PERF_W-1:0]        stallCount
);

  ctrl_state_e state_q, state_d;
  logic        load_use;

  assign load_use = memReadE && (writeRegE != '0) &&
                    ((writeRegE == readRegister1D) || (writeRegE == readRegister2D));

  always_comb begin
    state_d     = state_q;
    stallF      = 1'b0;
    stallD      = 1'b0;
    stallE      = 1'b0;
    stallM      = 1'b0;
    flushD      = 1'b0;
    flushE      = 1'b0;
    flushM      = 1'b0;
    flushW      = 1'b0;
    mulDivStart = 1'b0;
    case (state_q)
      CtrlMemWait: begin
        if (!dmemReady) begin
          stallF = 1'b1;
          stallD = 1'b1;
          stallE = 1'b1;
          stallM = 1'b1;
          flushW = 1'b1;
        end else begin
          state_d = CtrlRun;
        end
      end
      CtrlMdBusy: begin
        // Releasing on done lets the result latch into EX-MEM this cycle.
        if (!mulDivDone) begin
          stallF = 1'b1;
          stallD = 1'b1;
          stallE = 1'b1;
          flushM = 1'b1;
        end else begin
          state_d = CtrlRun;
        end
      end
      default: begin
        state_d = CtrlRun;
        if (memAccessM && !dmemReady) begin
          stallF  = 1'b1;
          stallD  = 1'b1;
          stallE  = 1'b1;
          stallM  = 1'b1;
          flushW  = 1'b1;
          state_d = CtrlMemWait;
        end else if (mulDivE) begin
          mulDivStart = 1'b1;
          stallF      = 1'b1;
          stallD      = 1'b1;
          stallE      = 1'b1;
          flushM      = 1'b1;
          state_d     = CtrlMdBusy;
        end else if (pcSrcE) begin
          // D holds a wrong-path instruction, so any load-use there is moot.
          flushD = 1'b1;
          flushE = 1'b1;
        end else if (load_use) begin
          stallF = 1'b1;
          stallD = 1'b1;
          flushE = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CtrlRun;
    end else begin
      state_q <= state_d;
    end
  end

  sat_counter #(
    .W(PERF_W)
  ) u_stall_counter (
    .clk  (clk),
    .clr  (reset),
    .en   (stallF),
    .count(stallCount)
  );

endmodule

// File: tb/tb_pipeline_control.sv
// Directed self-checking bench for pipeline_control (PERF_W=32 and PERF_W=4).
module tb_pipeline_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] readRegister1D, readRegister2D, writeRegE;
  logic       memReadE, pcSrcE, mulDivE, mulDivDone, memAccessM, dmemReady;

  logic        stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW, mulDivStart;
  logic [31:0] stallCount;
  logic        s_stallF, s_stallD, s_stallE, s_stallM;
  logic        s_flushD, s_flushE, s_flushM, s_flushW, s_mulDivStart;
  logic [3:0]  s_stallCount;

  logic [8:0] outs, s_outs;
  int total = 0;
  int bad = 0;

  // Output vector order: {sF, sD, sE, sM, fD, fE, fM, fW, mdStart}
  localparam logic [8:0] O_NONE  = 9'b000000000;
  localparam logic [8:0] O_LU    = 9'b110001000;
  localparam logic [8:0] O_BR    = 9'b000011000;
  localparam logic [8:0] O_MDST  = 9'b111000101;
  localparam logic [8:0] O_MDBSY = 9'b111000100;
  localparam logic [8:0] O_MEM   = 9'b111100010;

  assign outs   = {stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW, mulDivStart};
  assign s_outs = {s_stallF, s_stallD, s_stallE, s_stallM,
                   s_flushD, s_flushE, s_flushM, s_flushW, s_mulDivStart};

  always #5 clk = ~clk;

  pipeline_control #(.PERF_W(32)) dut (
    .clk(clk), .reset(reset),
    .readRegister1D(readRegister1D), .readRegister2D(readRegister2D), .writeRegE(writeRegE),
    .memReadE(memReadE), .pcSrcE(pcSrcE), .mulDivE(mulDivE), .mulDivDone(mulDivDone),
    .memAccessM(memAccessM), .dmemReady(dmemReady),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
    .mulDivStart(mulDivStart), .stallCount(stallCount)
  );

  pipeline_control #(.PERF_W(4)) dut_small (
    .clk(clk), .reset(reset),
    .readRegister1D(readRegister1D), .readRegister2D(readRegister2D), .writeRegE(writeRegE),
    .memReadE(memReadE), .pcSrcE(pcSrcE), .mulDivE(mulDivE), .mulDivDone(mulDivDone),
    .memAccessM(memAccessM), .dmemReady(dmemReady),
    .stallF(s_stallF), .stallD(s_stallD), .stallE(s_stallE), .stallM(s_stallM),
    .flushD(s_flushD), .flushE(s_flushE), .flushM(s_flushM), .flushW(s_flushW),
    .mulDivStart(s_mulDivStart), .stallCount(s_stallCount)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    readRegister1D = '0;
    readRegister2D = '0;
    writeRegE      = '0;
    memReadE       = 1'b0;
    pcSrcE         = 1'b0;
    mulDivE        = 1'b0;
    mulDivDone     = 1'b0;
    memAccessM     = 1'b0;
    dmemReady      = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (outs !== O_NONE) begin
      bad++;
      $display("FAIL reset_outs: got %b want %b", outs, O_NONE);
    end
    total++;
    if (s_outs !== O_NONE) begin
      bad++;
      $display("FAIL reset_outs_small: got %b want %b", s_outs, O_NONE);
    end
    total++;
    if (stallCount !== 32'd0) begin
      bad++;
      $display("FAIL reset_count: got %0d want 0", stallCount);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    memReadE = 1'b1; writeRegE = 5'd5; readRegister2D = 5'd5;
    #1;
    total++;
    if (outs !== O_LU) begin
      bad++;
      $display("FAIL load_use_rs2: got %b want %b", outs, O_LU);
    end
    tick();
    idle_inputs();
    #1;
    total++;
    if (outs !== O_NONE) begin
      bad++;
      $display("FAIL load_use_after: got %b want %b", outs, O_NONE);
    end
    total++;
    if (stallCount !== 32'd1) begin
      bad++;
      $display("FAIL load_use_count: got %0d want 1", stallCount);
    end
    memReadE = 1'b1; writeRegE = 5'd7; readRegister1D = 5'd7;
    #1;
    total++;
    if (outs !== O_LU) begin
      bad++;
      $display("FAIL load_use_rs1: got %b want %b", outs, O_LU);
    end
    writeRegE = 5'd0; readRegister1D = 5'd0; readRegister2D = 5'd0;
    #1;
    total++;
    if (outs !== O_NONE) begin
      bad++;
      $display("FAIL load_use_x0: got %b want %b", outs, O_NONE);
    end
    writeRegE = 5'd3; readRegister1D = 5'd4; readRegister2D = 5'd6;
    #1;
    total++;
    if (outs !== O_NONE) begin
      bad++;
      $display("FAIL load_use_nomatch: got %b want %b", outs, O_NONE);
    end
    memReadE = 1'b0; readRegister1D = 5'd3;
    #1;
    total++;
    if (outs !== O_NONE) begin
      bad++;
      $display("FAIL load_use_notload: got %b want %b", outs, O_NONE);
    end
    idle_inputs();
  endtask

  task automatic test_branch();
    do_reset();
    memReadE = 1'b1; writeRegE = 5'd5; readRegister2D = 5'd5; pcSrcE = 1'b1;
    #1;
    total++;
    if (outs !== O_BR) begin
      bad++;
      $display("FAIL branch_over_lu: got %b want %b", outs, O_BR);
    end
    tick();
    idle_inputs();
    #1;
    total++;
    if (stallCount !== 32'd0) begin
      bad++;
      $display("FAIL branch_count: got %0d want 0", stallCount);
    end
    memAccessM = 1'b1; dmemReady = 1'b0; pcSrcE = 1'b1;
    #1;
    total++;
    if (outs !== O_MEM) begin
      bad++;
      $display("FAIL mem_over_branch: got %b want %b", outs, O_MEM);
    end
    dmemReady = 1'b1; pcSrcE = 1'b0; memAccessM = 1'b0;
  endtask

  task automatic test_muldiv();
    logic [8:0] exp;
    do_reset();
    mulDivE = 1'b1;
    for (int c = 0; c < 5; c++) begin
      mulDivDone = (c == 4);
      #1;
      exp = (c == 0) ? O_MDST : ((c == 4) ? O_NONE : O_MDBSY);
      total++;
      if (outs !== exp) begin
        bad++;
        $display("FAIL muldiv_cycle%0d: got %b want %b", c, outs, exp);
      end
      tick();
    end
    idle_inputs();
    #1;
    total++;
    if (outs !== O_NONE) begin
      bad++;
      $display("FAIL muldiv_after: got %b want %b", outs, O_NONE);
    end
    total++;
    if (stallCount !== 32'd4) begin
      bad++;
      $display("FAIL muldiv_count: got %0d want 4", stallCount);
    end
  endtask

  task automatic test_mem_then_muldiv();
    logic [8:0] exp;
    do_reset();
    mulDivE = 1'b1; memAccessM = 1'b1;
    for (int c = 0; c < 4; c++) begin
      dmemReady  = (c >= 2);
      memAccessM = (c <= 2);
      #1;
      exp = (c < 2) ? O_MEM : ((c == 2) ? O_NONE : O_MDST);
      total++;
      if (outs !== exp) begin
        bad++;
        $display("FAIL mem_md_cycle%0d: got %b want %b", c, outs, exp);
      end
      tick();
    end
    total++;
    if (stallCount !== 32'd3) begin
      bad++;
      $display("FAIL mem_md_count: got %0d want 3", stallCount);
    end
    mulDivDone = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid_muldiv();
    do_reset();
    mulDivE = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mulDivE = 1'b0;
    #1;
    total++;
    if (outs !== O_NONE) begin
      bad++;
      $display("FAIL rst_md_outs: got %b want %b", outs, O_NONE);
    end
    total++;
    if (stallCount !== 32'd0) begin
      bad++;
      $display("FAIL rst_md_count: got %0d want 0", stallCount);
    end
    mulDivDone = 1'b1;
    #1;
    total++;
    if (outs !== O_NONE) begin
      bad++;
      $display("FAIL rst_md_done_ignored: got %b want %b", outs, O_NONE);
    end
    tick();
    mulDivDone = 1'b0;
    #1;
    total++;
    if (outs !== O_NONE || stallCount !== 32'd0) begin
      bad++;
      $display("FAIL rst_md_later: got %b/%0d want %b/0", outs, stallCount, O_NONE);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    memAccessM = 1'b1; dmemReady = 1'b0;
    for (int c = 0; c < 20; c++) tick();
    total++;
    if (s_stallCount !== 4'd15) begin
      bad++;
      $display("FAIL sat_small: got %0d want 15", s_stallCount);
    end
    total++;
    if (stallCount !== 32'd20) begin
      bad++;
      $display("FAIL sat_wide: got %0d want 20", stallCount);
    end
    dmemReady = 1'b1;
    tick();
    idle_inputs();
    #1;
    total++;
    if (s_outs !== O_NONE || s_stallCount !== 4'd15) begin
      bad++;
      $display("FAIL sat_release: got %b/%0d want %b/15", s_outs, s_stallCount, O_NONE);
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_load_use();
    test_branch();
    test_muldiv();
    test_mem_then_muldiv();
    test_reset_mid_muldiv();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
